hazard_ctrl: RTL and testbench

- Sequencing controller for the 16-bit SIMD AES pipeline (IF, ID, EX, MEM, WB).
- Holds a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB).
- Detects read-after-write hazards on the instruction in ID and drives PC/IF-ID enables, ID/EX bubble insertion and IF/ID flush on taken branches.
- Optionally produces registered forwarding selects for the ALU operand muxes, plus a stall counter for performance checks.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_match.sv | 17 +
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the SIMD AES pipeline sequencing logic.
//   sb_entry_t  - one scoreboard slot describing an in-flight producer
//   fwd_sel_t   - ALU operand source select encoding
//   SB_NOP      - empty scoreboard slot (bubble)
//   pick_fwd    - newest-producer-wins forwarding priority
package pipe_pkg;

    // Widest register address any pipeline instance may use; narrower
    // address widths are zero-extended into the scoreboard.
    localparam int unsigned RD_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                reg_w;
        logic                mem_r;
    } sb_entry_t;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_EXMEM  = 2'b01,
        FWD_MEMWB  = 2'b10,
        FWD_WBHOLD = 2'b11
    } fwd_sel_t;

    localparam sb_entry_t SB_NOP = '{valid: 1'b0, rd: '0, reg_w: 1'b0, mem_r: 1'b0};

    // The youngest matching producer holds the architecturally newest value.
    function automatic fwd_sel_t pick_fwd(input logic m_ex, input logic m_mem, input logic m_wb);
        if (m_ex)
            return FWD_EXMEM;
        else if (m_mem)
            return FWD_MEMWB;
        else if (m_wb)
            return FWD_WBHOLD;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage instruction fields and pipeline control outputs
// exchanged between the pipeline datapath (master) and hazard_ctrl (slave).
//   id_*          - decoded fields of the instruction currently in ID
//   branch_taken  - EX resolved a taken branch this cycle
//   pc_en/ifid_en - front-end advance enables
//   ifid_flush    - clear IF/ID to NOP
//   idex_bubble   - load NOP into ID/EX
//   fwd_a/fwd_b   - registered ALU operand selects
//   stall_count   - saturating stall cycle counter
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_w;
    logic              id_mem_r;
    logic              branch_taken;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_w, id_mem_r, branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_w, id_mem_r, branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_count
    );

endinterface

// File: rtl/hazard_match.sv
// hazard_match: compares one ID source register against one scoreboard slot.
//   src     - zero-extended source register address
//   use_src - the ID instruction actually reads this source
//   entry   - scoreboard slot
//   match   - slot holds a register-writing producer of src
module hazard_match
    import pipe_pkg::*;
(
    input  logic [RD_MAX_W-1:0] src,
    input  logic                use_src,
    input  sb_entry_t           entry,
    output logic                match
);

    assign match = use_src && entry.valid && entry.reg_w && (entry.rd == src);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, stall/flush sequencing and operand
// forwarding selection for the 5-stage SIMD AES pipeline.
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - hazard_ctrl_if slave: ID fields in, control/forwarding out
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FORWARD = 1,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    localparam int unsigned ST_EX  = 0;
    localparam int unsigned ST_MEM = 1;
    localparam int unsigned ST_WB  = 2;

    sb_entry_t           sb_q [3];
    fwd_sel_t            fwd_a_q;
    fwd_sel_t            fwd_b_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [RD_MAX_W-1:0] rs1_x;
    logic [RD_MAX_W-1:0] rs2_x;
    logic [RD_MAX_W-1:0] rd_x;
    logic [2:0]          m_a;
    logic [2:0]          m_b;
    logic                hazard;
    logic                pc_en;
    logic                ifid_en;
    logic                ifid_flush;
    logic                idex_bubble;
    logic                issue;

    assign rs1_x = RD_MAX_W'(bus.id_rs1[REG_AW-1:0]);
    assign rs2_x = RD_MAX_W'(bus.id_rs2[REG_AW-1:0]);
    assign rd_x  = RD_MAX_W'(bus.id_rd[REG_AW-1:0]);

    for (genvar g = 0; g < 3; g++) begin : g_match
        hazard_match u_match_a (
            .src     (rs1_x),
            .use_src (bus.id_use_rs1),
            .entry   (sb_q[g]),
            .match   (m_a[g])
        );
        hazard_match u_match_b (
            .src     (rs2_x),
            .use_src (bus.id_use_rs2),
            .entry   (sb_q[g]),
            .match   (m_b[g])
        );
    end

    // With forwarding only a load sitting in EX cannot supply its result in
    // time; without it any in-flight producer blocks until its WB write.
    always_comb begin
        hazard = 1'b0;
        if (bus.id_valid) begin
            if (FORWARD != 0)
                hazard = (m_a[ST_EX] || m_b[ST_EX]) && sb_q[ST_EX].mem_r;
            else
                hazard = (|m_a) || (|m_b);
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign issue = bus.id_valid && !idex_bubble;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_q[ST_EX]  <= SB_NOP;
            sb_q[ST_MEM] <= SB_NOP;
            sb_q[ST_WB]  <= SB_NOP;
            fwd_a_q      <= FWD_RF;
            fwd_b_q      <= FWD_RF;
            cnt_q        <= '0;
        end else begin
            sb_q[ST_WB]  <= sb_q[ST_MEM];
            sb_q[ST_MEM] <= sb_q[ST_EX];
            if (issue)
                sb_q[ST_EX] <= '{valid: 1'b1, rd: rd_x, reg_w: bus.id_reg_w, mem_r: bus.id_mem_r};
            else
                sb_q[ST_EX] <= SB_NOP;

            // A load match in EX never issues (it stalls), so the EX term
            // only ever selects an ALU result here.
            if ((FORWARD != 0) && issue) begin
                fwd_a_q <= pick_fwd(m_a[ST_EX] && !sb_q[ST_EX].mem_r, m_a[ST_MEM], m_a[ST_WB]);
                fwd_b_q <= pick_fwd(m_b[ST_EX] && !sb_q[ST_EX].mem_r, m_b[ST_MEM], m_b[ST_WB]);
            end else begin
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end

            if (hazard && !bus.branch_taken && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.fwd_a       = fwd_a_q;
    assign bus.fwd_b       = fwd_b_q;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int unsigned CNT0_W = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Shadow copies of the driven ID fields, read by the reference model.
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_w, id_mem_r, branch_taken;
    logic [3:0] id_rs1, id_rs2, id_rd;

    // Instance 0: no forwarding, narrow counter so saturation is reachable.
    // Instance 1: forwarding, full 16-bit counter.
    hazard_ctrl_if #(.REG_AW(4), .CNT_W(CNT0_W)) bus0 ();
    hazard_ctrl_if #(.REG_AW(4), .CNT_W(16))     bus1 ();

    hazard_ctrl #(.FORWARD(0), .REG_AW(4), .CNT_W(CNT0_W)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    hazard_ctrl #(.FORWARD(1), .REG_AW(4), .CNT_W(16)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    logic        pc_en_o [2];
    logic        ifid_en_o [2];
    logic        flush_o [2];
    logic        bubble_o [2];
    logic [1:0]  fa_o [2];
    logic [1:0]  fb_o [2];
    logic [15:0] cnt_o [2];

    assign pc_en_o[0]   = bus0.pc_en;
    assign pc_en_o[1]   = bus1.pc_en;
    assign ifid_en_o[0] = bus0.ifid_en;
    assign ifid_en_o[1] = bus1.ifid_en;
    assign flush_o[0]   = bus0.ifid_flush;
    assign flush_o[1]   = bus1.ifid_flush;
    assign bubble_o[0]  = bus0.idex_bubble;
    assign bubble_o[1]  = bus1.idex_bubble;
    assign fa_o[0]      = bus0.fwd_a;
    assign fa_o[1]      = bus1.fwd_a;
    assign fb_o[0]      = bus0.fwd_b;
    assign fb_o[1]      = bus1.fwd_b;
    assign cnt_o[0]     = 16'(bus0.stall_count);
    assign cnt_o[1]     = bus1.stall_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: history of what entered EX in the last three cycles
    // (index 0 = one cycle ago). A producer's distance in cycles decides
    // both the stall rule and the forwarding source.
    logic        hv [2][3];
    logic [3:0]  hrd [2][3];
    logic        hw [2][3];
    logic        hm [2][3];
    int unsigned m_cnt [2];
    logic [1:0]  m_fa [2];
    logic [1:0]  m_fb [2];
    logic        obs_pc [2];

    function automatic int unsigned cnt_max(input int d);
        return (d == 0) ? ((1 << CNT0_W) - 1) : 65535;
    endfunction

    function automatic int unsigned age_of(input int d, input logic [3:0] src, input logic use_s);
        for (int k = 0; k < 3; k++)
            if (use_s && hv[d][k] && hw[d][k] && hrd[d][k] == src)
                return k + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                hv[d][k] = 1'b0; hrd[d][k] = '0; hw[d][k] = 1'b0; hm[d][k] = 1'b0;
            end
            m_cnt[d] = 0; m_fa[d] = 2'b00; m_fb[d] = 2'b00;
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                          input logic u1, input logic u2, input logic [3:0] rd,
                          input logic w, input logic mr, input logic br);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_w = w; id_mem_r = mr; branch_taken = br;
        bus0.id_valid = v; bus0.id_rs1 = r1; bus0.id_rs2 = r2; bus0.id_use_rs1 = u1;
        bus0.id_use_rs2 = u2; bus0.id_rd = rd; bus0.id_reg_w = w; bus0.id_mem_r = mr;
        bus0.branch_taken = br;
        bus1.id_valid = v; bus1.id_rs1 = r1; bus1.id_rs2 = r2; bus1.id_use_rs1 = u1;
        bus1.id_use_rs2 = u2; bus1.id_rd = rd; bus1.id_reg_w = w; bus1.id_mem_r = mr;
        bus1.branch_taken = br;
    endtask

    // One clock cycle: check combinational controls mid-cycle, then the
    // registered outputs just after the rising edge.
    task automatic step();
        int unsigned a1 [2];
        int unsigned a2 [2];
        logic haz [2];
        logic acc [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            a1[d] = age_of(d, id_rs1, id_use_rs1);
            a2[d] = age_of(d, id_rs2, id_use_rs2);
            if (d == 0)
                haz[d] = id_valid && (a1[d] != 0 || a2[d] != 0);
            else
                haz[d] = id_valid && (a1[d] == 1 || a2[d] == 1) && hm[d][0];
            acc[d] = id_valid && !(branch_taken || haz[d]);
            obs_pc[d] = pc_en_o[d];
            chk($sformatf("pc_en%0d", d),   pc_en_o[d],   !haz[d] || branch_taken);
            chk($sformatf("ifid_en%0d", d), ifid_en_o[d], !haz[d] || branch_taken);
            chk($sformatf("flush%0d", d),   flush_o[d],   branch_taken);
            chk($sformatf("bubble%0d", d),  bubble_o[d],  branch_taken || haz[d]);
        end
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (haz[d] && !branch_taken && m_cnt[d] < cnt_max(d))
                m_cnt[d]++;
            m_fa[d] = (d == 1 && acc[d]) ? 2'(a1[d]) : 2'b00;
            m_fb[d] = (d == 1 && acc[d]) ? 2'(a2[d]) : 2'b00;
            for (int k = 2; k > 0; k--) begin
                hv[d][k] = hv[d][k-1]; hrd[d][k] = hrd[d][k-1];
                hw[d][k] = hw[d][k-1]; hm[d][k] = hm[d][k-1];
            end
            hv[d][0] = acc[d]; hrd[d][0] = id_rd; hw[d][0] = id_reg_w; hm[d][0] = id_mem_r;
            chk($sformatf("fwd_a%0d", d), fa_o[d],  m_fa[d]);
            chk($sformatf("fwd_b%0d", d), fb_o[d],  m_fb[d]);
            chk($sformatf("cnt%0d", d),   cnt_o[d], m_cnt[d]);
        end
    endtask

    task automatic drain();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
    endtask

    int unsigned stalls0, stalls1;
    logic [15:0] cnt_before;

    initial begin
        model_reset();
        // Reset with a real instruction in ID reading r3.
        reset = 1'b0;
        set_id(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_pc_en%0d", d),  pc_en_o[d],  1'b1);
            chk($sformatf("rst_bubble%0d", d), bubble_o[d], 1'b0);
            chk($sformatf("rst_fwd_a%0d", d),  fa_o[d],     2'b00);
            chk($sformatf("rst_cnt%0d", d),    cnt_o[d],    16'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        drain();

        // No forwarding: back-to-back dependency stalls three cycles.
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        step();
        cnt_before = cnt_o[0];
        stalls0 = 0; stalls1 = 0;
        set_id(1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        repeat (4) begin
            step();
            if (!obs_pc[0]) stalls0++;
            if (!obs_pc[1]) stalls1++;
        end
        chk("f0_stall_cycles", stalls0, 3);
        chk("f1_alu_no_stall", stalls1, 0);
        chk("f0_cnt_delta", cnt_o[0] - cnt_before, 3);
        drain();

        // Forwarding: ALU result consumed by the next instruction.
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        step();
        chk("alu_use_pc_en", obs_pc[1], 1'b1);
        chk("alu_use_fwd_a", fa_o[1], 2'b01);
        chk("alu_use_fwd_b", fb_o[1], 2'b01);
        drain();

        // Load-use: one stall, then MEM/WB, then WB-hold forwarding.
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 4'd7, 4'd1, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
        step();
        chk("ld_use_stall", obs_pc[1], 1'b0);
        step();
        chk("ld_use_release", obs_pc[1], 1'b1);
        chk("ld_use_fwd_a", fa_o[1], 2'b10);
        set_id(1'b1, 4'd7, 4'd6, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        step();
        chk("ld_wb_fwd_a", fa_o[1], 2'b11);
        drain();

        // Taken branch during a load-use hazard: flush wins, nothing counted.
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
        step();
        cnt_before = cnt_o[1];
        set_id(1'b1, 4'd7, 4'd1, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1);
        step();
        chk("br_flush", flush_o[1], 1'b1);
        chk("br_pc_en", obs_pc[1], 1'b1);
        chk("br_cnt_hold", cnt_o[1], cnt_before);
        set_id(1'b1, 4'd8, 4'd8, 1'b1, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
        step();
        chk("br_ex_invalid_fwd", fa_o[1], 2'b00);
        drain();

        // Reset asserted in the middle of a stall.
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        step();
        chk("pre_rst_stall", obs_pc[0], 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_pc_en", pc_en_o[0], 1'b1);
        chk("mid_rst_bubble", bubble_o[0], 1'b0);
        chk("mid_rst_cnt", cnt_o[0], 16'd0);
        chk("mid_rst_fwd", fa_o[1], 2'b00);
        reset = 1'b1;
        step();

        // Random traffic over a small register set to drive frequent hazards.
        for (int n = 0; n < 1500; n++) begin
            set_id($urandom_range(0, 9) < 8,
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
                   $urandom_range(0, 9) == 0);
            step();
        end
        chk("cnt0_saturated", cnt_o[0], 16'h00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
